// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the round-robin APB bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  localparam int unsigned TIMEOUT_DISABLE = 0;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo.sv
// Parameterised show-ahead FIFO; pointers carry an extra wrap bit to tell full from empty.
module fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr, pointer moves past the winner.
module rr_arbiter
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic                             enable,
  output logic [NUM_REQ-1:0]               grant,
  output logic [id_width(NUM_REQ)-1:0]     grant_id
);

  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0] rr_ptr;
  logic            found;

  // First pass covers ports at or above rr_ptr, second pass wraps to the low ports.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (enable && !found && req[k] && (ID_W'(k) >= rr_ptr)) begin
        grant[k] = 1'b1;
        grant_id = ID_W'(k);
        found    = 1'b1;
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (enable && !found && req[k]) begin
        grant[k] = 1'b1;
        grant_id = ID_W'(k);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/apb_rr_bridge.sv
// Multi-requester APB bridge: round-robin accept into a command queue, in-order APB
// transfers with optional wait-state timeout, one registered response per command.
module apb_rr_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
  output logic                          rsp_valid_o,
  output logic [id_width(NUM_REQ)-1:0]  rsp_id_o,
  output logic                          rsp_write_o,
  output logic [DATA_W-1:0]             rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          psel_o,
  output logic                          penable_o,
  output logic                          pwrite_o,
  output logic [ADDR_W-1:0]             paddr_o,
  output logic [DATA_W-1:0]             pwdata_o,
  input  logic                          pready_i,
  input  logic                          pslverr_i,
  input  logic [DATA_W-1:0]             prdata_i
);

  localparam int unsigned ID_W    = id_width(NUM_REQ);
  localparam int unsigned ENTRY_W = ID_W + 1 + ADDR_W + DATA_W;
  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               q_full;
  logic               q_empty;
  logic               q_pop;
  logic [ENTRY_W-1:0] q_head;
  logic               push_write;
  logic [ADDR_W-1:0]  push_addr;
  logic [DATA_W-1:0]  push_wdata;

  apb_state_t         state;
  logic [ID_W-1:0]    cmd_id;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timeout_hit;
  logic               done;

  // Reset gating keeps req_ready_o low while reset is held, independent of queue state.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req_valid_i),
    .enable   (!q_full && !reset),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready_o = grant;

  always_comb begin
    push_write = 1'b0;
    push_addr  = '0;
    push_wdata = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        push_write = req_write_i[k];
        push_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
        push_wdata = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
  end

  fifo #(.DATA_W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_cmd_q (
    .clk   (clk),
    .reset (reset),
    .push  (|grant),
    .wdata ({grant_id, push_write, push_addr, push_wdata}),
    .pop   (q_pop),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign timeout_hit = (TIMEOUT != TIMEOUT_DISABLE) && !pready_i &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign done        = (state == ACCESS) && (pready_i || timeout_hit);
  assign q_pop       = !q_empty && ((state == IDLE) || done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_id      <= '0;
      wait_cnt    <= '0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_write_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (q_pop) {cmd_id, pwrite_o, paddr_o, pwdata_o} <= q_head;
      case (state)
        IDLE: begin
          if (!q_empty) begin
            state  <= SETUP;
            psel_o <= 1'b1;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
          wait_cnt  <= '0;
        end
        ACCESS: begin
          if (done) begin
            rsp_valid_o <= 1'b1;
            rsp_id_o    <= cmd_id;
            rsp_write_o <= pwrite_o;
            // Completion without pready can only be a timeout.
            rsp_err_o   <= !pready_i || pslverr_i;
            rsp_rdata_o <= (pready_i && !pslverr_i && !pwrite_o) ? prdata_i : '0;
            penable_o   <= 1'b0;
            if (!q_empty) begin
              state <= SETUP;
            end else begin
              state  <= IDLE;
              psel_o <= 1'b0;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_bridge.sv
// Directed bench for apb_rr_bridge with a simple APB completer and response logger.
module tb_apb_rr_bridge;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ-1:0]        req_write_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic                      rsp_valid_o;
  logic [0:0]                rsp_id_o;
  logic                      rsp_write_o;
  logic [DATA_W-1:0]         rsp_rdata_o;
  logic                      rsp_err_o;
  logic                      psel_o;
  logic                      penable_o;
  logic                      pwrite_o;
  logic [ADDR_W-1:0]         paddr_o;
  logic [DATA_W-1:0]         pwdata_o;
  logic                      pready_i;
  logic                      pslverr_i;
  logic [DATA_W-1:0]         prdata_i;

  logic                      pready_en;
  logic                      slverr_en;
  logic                      use_addr;
  logic [DATA_W-1:0]         prdata_val;

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc_no     = 0;
  int          onehot_err = 0;
  int          psel_cnt   = 0;
  int          access_cnt = 0;
  int          grant_cnt  = 0;
  int          rsp_cnt    = 0;
  int          grant_log   [64];
  int          rsp_id_log  [64];
  int          rsp_wr_log  [64];
  int          rsp_err_log [64];
  int          rsp_cyc_log [64];
  logic [31:0] rsp_rd_log  [64];

  apb_rr_bridge #(
    .NUM_REQ    (NUM_REQ),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (4),
    .TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_write_o (rsp_write_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i),
    .prdata_i    (prdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completer: answers in ACCESS when enabled; read data can echo the address.
  assign pready_i  = psel_o & penable_o & pready_en;
  assign pslverr_i = psel_o & penable_o & pready_en & slverr_en;
  assign prdata_i  = use_addr ? {16'hD00D, paddr_o[15:0]} : prdata_val;

  // Monitor samples one time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    cyc_no++;
    if ($countones(req_ready_o) > 1) onehot_err++;
    if (psel_o) psel_cnt++;
    if (psel_o && penable_o) access_cnt++;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[k] && req_ready_o[k] && grant_cnt < 64) begin
        grant_log[grant_cnt] = k;
        grant_cnt++;
      end
    end
    if (rsp_valid_o && rsp_cnt < 64) begin
      rsp_id_log[rsp_cnt]  = int'(rsp_id_o);
      rsp_wr_log[rsp_cnt]  = int'(rsp_write_o);
      rsp_err_log[rsp_cnt] = int'(rsp_err_o);
      rsp_rd_log[rsp_cnt]  = rsp_rdata_o;
      rsp_cyc_log[rsp_cnt] = cyc_no;
      rsp_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic send(input int p, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    int guard;
    guard = 0;
    req_valid_i[p]               = 1'b1;
    req_write_i[p]               = wr;
    req_addr_i[p*ADDR_W +: 32]   = addr;
    req_wdata_i[p*DATA_W +: 32]  = wd;
    #1;
    while (!req_ready_o[p] && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check($sformatf("send_accept_p%0d_%0h", p, addr), req_ready_o[p], 1'b1);
    @(negedge clk);
    req_valid_i[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int limit);
    int g;
    g = 0;
    while (rsp_cnt < n && g < limit) begin
      @(negedge clk);
      g++;
    end
    check($sformatf("rsp_arrived_%0d", n), rsp_cnt >= n, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    req_valid_i = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int p0, gb, rb, acc0, g;
    reset       = 1'b1;
    req_valid_i = '1;
    req_write_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    pready_en   = 1'b1;
    slverr_en   = 1'b0;
    use_addr    = 1'b0;
    prdata_val  = 32'hA5A5_0001;

    // Reset state, with both requesters asserting valid.
    @(negedge clk);
    #1;
    check("rst_ready",     req_ready_o, 2'b00);
    check("rst_psel",      psel_o, 1'b0);
    check("rst_penable",   penable_o, 1'b0);
    check("rst_pwrite",    pwrite_o, 1'b0);
    check("rst_paddr",     paddr_o, 32'h0);
    check("rst_pwdata",    pwdata_o, 32'h0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rsp_id",    rsp_id_o, 1'b0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'h0);
    check("rst_rsp_err",   rsp_err_o, 1'b0);
    req_valid_i = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait read from port 0.
    p0 = psel_cnt;
    req_valid_i[0]     = 1'b1;
    req_write_i[0]     = 1'b0;
    req_addr_i[31:0]   = 32'h10;
    #1;
    check("rd_ready", req_ready_o, 2'b01);
    @(negedge clk);
    req_valid_i[0] = 1'b0;
    #1;
    check("rd_idle_psel", psel_o, 1'b0);
    @(negedge clk);
    check("rd_setup_psel",    psel_o, 1'b1);
    check("rd_setup_penable", penable_o, 1'b0);
    check("rd_setup_paddr",   paddr_o, 32'h10);
    check("rd_setup_pwrite",  pwrite_o, 1'b0);
    @(negedge clk);
    check("rd_access_penable", penable_o, 1'b1);
    check("rd_access_paddr",   paddr_o, 32'h10);
    @(negedge clk);
    check("rd_rsp_valid", rsp_valid_o, 1'b1);
    check("rd_rsp_id",    rsp_id_o, 1'b0);
    check("rd_rsp_rdata", rsp_rdata_o, 32'hA5A5_0001);
    check("rd_rsp_err",   rsp_err_o, 1'b0);
    check("rd_rsp_write", rsp_write_o, 1'b0);
    check("rd_done_psel", psel_o, 1'b0);
    @(negedge clk);
    check("rd_rsp_one_cycle", rsp_valid_o, 1'b0);
    check("rd_psel_cycles",   psel_cnt - p0, 2);

    // Fairness: both ports hold valid for six accepts.
    do_reset();
    use_addr          = 1'b1;
    req_write_i       = 2'b10;
    req_addr_i[31:0]  = 32'h100;
    req_addr_i[63:32] = 32'h200;
    req_wdata_i[63:32] = 32'hCAFE_0001;
    gb = grant_cnt;
    rb = rsp_cnt;
    req_valid_i = 2'b11;
    g = 0;
    while (grant_cnt - gb < 6 && g < 100) begin
      @(negedge clk);
      g++;
    end
    req_valid_i = '0;
    check("fair_accepts", grant_cnt - gb, 6);
    wait_rsp(rb + 6, 100);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fair_grant%0d", i), grant_log[gb+i], i % 2);
      check($sformatf("fair_rsp_id%0d", i), rsp_id_log[rb+i], i % 2);
      check($sformatf("fair_rsp_wr%0d", i), rsp_wr_log[rb+i], i % 2);
      check($sformatf("fair_rsp_rd%0d", i), rsp_rd_log[rb+i],
            (i % 2 == 0) ? 32'hD00D_0100 : 32'h0);
    end

    // Full queue: pready held low while port 1 queues five reads.
    pready_en   = 1'b0;
    req_write_i = '0;
    gb = grant_cnt;
    rb = rsp_cnt;
    for (int i = 0; i < 5; i++) send(1, 1'b0, 32'h300 + i, 32'h0);
    req_valid_i[0]   = 1'b1;
    req_addr_i[31:0] = 32'hBAD;
    #1;
    check("full_no_grant_a",  req_ready_o, 2'b00);
    check("full_in_access",   psel_o && penable_o, 1'b1);
    @(negedge clk);
    #1;
    check("full_no_grant_b",  req_ready_o, 2'b00);
    req_valid_i[0] = 1'b0;
    pready_en      = 1'b1;
    wait_rsp(rb + 5, 60);
    check("full_accepts", grant_cnt - gb, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("full_rsp_id%0d", i),  rsp_id_log[rb+i], 1);
      check($sformatf("full_rsp_rd%0d", i),  rsp_rd_log[rb+i], 32'hD00D_0300 + i);
      check($sformatf("full_rsp_err%0d", i), rsp_err_log[rb+i], 0);
    end
    for (int i = 1; i < 5; i++)
      check($sformatf("full_b2b_gap%0d", i), rsp_cyc_log[rb+i] - rsp_cyc_log[rb+i-1], 2);

    // Slave error on a write, then on a read.
    slverr_en = 1'b1;
    rb = rsp_cnt;
    send(0, 1'b1, 32'h20, 32'h55);
    @(negedge clk);
    check("err_setup_pwrite", pwrite_o, 1'b1);
    check("err_setup_pwdata", pwdata_o, 32'h55);
    wait_rsp(rb + 1, 20);
    check("err_wr_err",   rsp_err_log[rb], 1);
    check("err_wr_rdata", rsp_rd_log[rb], 32'h0);
    check("err_wr_write", rsp_wr_log[rb], 1);
    send(0, 1'b0, 32'h24, 32'h0);
    wait_rsp(rb + 2, 20);
    check("err_rd_err",   rsp_err_log[rb+1], 1);
    check("err_rd_rdata", rsp_rd_log[rb+1], 32'h0);
    slverr_en = 1'b0;

    // Timeout on a read from port 0, followed by a queued read from port 1.
    pready_en = 1'b0;
    rb   = rsp_cnt;
    acc0 = access_cnt;
    send(0, 1'b0, 32'h30, 32'h0);
    send(1, 1'b0, 32'h40, 32'h0);
    wait_rsp(rb + 1, 60);
    check("to_access_cycles", access_cnt - acc0, 16);
    check("to_err",   rsp_err_log[rb], 1);
    check("to_rdata", rsp_rd_log[rb], 32'h0);
    check("to_id",    rsp_id_log[rb], 0);
    pready_en = 1'b1;
    wait_rsp(rb + 2, 20);
    check("to_next_id",    rsp_id_log[rb+1], 1);
    check("to_next_err",   rsp_err_log[rb+1], 0);
    check("to_next_rdata", rsp_rd_log[rb+1], 32'hD00D_0040);

    // Reset during the third ACCESS cycle with two commands queued.
    pready_en = 1'b0;
    send(1, 1'b0, 32'h50, 32'h0);
    send(1, 1'b0, 32'h60, 32'h0);
    send(0, 1'b0, 32'h70, 32'h0);
    g = 0;
    while (!(psel_o && penable_o) && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("mid_in_access", psel_o && penable_o, 1'b1);
    repeat (2) @(negedge clk);
    rb = rsp_cnt;
    reset       = 1'b1;
    req_valid_i = 2'b11;
    #1;
    check("mid_rst_psel",    psel_o, 1'b0);
    check("mid_rst_penable", penable_o, 1'b0);
    check("mid_rst_ready",   req_ready_o, 2'b00);
    @(negedge clk);
    req_valid_i = '0;
    @(negedge clk);
    reset     = 1'b0;
    pready_en = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_post_psel",  psel_o, 1'b0);
    check("mid_post_norsp", rsp_cnt - rb, 0);
    req_addr_i[31:0]  = 32'h80;
    req_addr_i[63:32] = 32'h90;
    req_write_i       = '0;
    req_valid_i       = 2'b11;
    #1;
    check("mid_first_grant", req_ready_o, 2'b01);
    @(negedge clk);
    req_valid_i = '0;
    wait_rsp(rb + 1, 20);
    check("mid_rsp_id",    rsp_id_log[rb], 0);
    check("mid_rsp_rdata", rsp_rd_log[rb], 32'hD00D_0080);

    check("ready_onehot", onehot_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
